// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and depth constant for the pipeline skid register
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
  localparam logic [1:0] SKID_DEPTH = 2'd2;
endpackage

// File: rtl/reg_en.sv
// reg_en: N-bit register with load enable and async active-high reset to INIT
module reg_en #(
  parameter int N = 32,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= INIT;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid pipeline register with registered upstream ready
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int N = 32,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);
  skid_state_t state, nxt;
  logic main_en, skid_en, sel_skid;
  logic [N-1:0] skid_q, main_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= nxt;
  // flush wins over every handshake and leaves the data registers untouched
  always_comb begin
    nxt = state;
    main_en = 1'b0;
    skid_en = 1'b0;
    sel_skid = 1'b0;
    if (flush) nxt = EMPTY;
    else
      case (state)
        EMPTY: if (in_valid) begin
          main_en = 1'b1;
          nxt = ONE;
        end
        ONE: if (out_ready) begin
          main_en = in_valid;
          nxt = in_valid ? ONE : EMPTY;
        end else if (in_valid) begin
          skid_en = 1'b1;
          nxt = FULL;
        end
        FULL: if (out_ready) begin
          main_en = 1'b1;
          sel_skid = 1'b1;
          nxt = ONE;
        end
        default: nxt = EMPTY;
      endcase
  end
  always_comb begin
    out_valid = state != EMPTY;
    in_ready = state != FULL;
    count = state == FULL ? SKID_DEPTH : state == ONE ? 2'd1 : 2'd0;
    main_d = sel_skid ? skid_q : in_data;
  end
  reg_en #(.N(N), .INIT(INIT)) u_main (
    .clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(out_data)
  );
  reg_en #(.N(N), .INIT(INIT)) u_skid (
    .clk(clk), .rst(rst), .en(skid_en), .d(in_data), .q(skid_q)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: queue-model checking of pipe_skid_reg with directed and random traffic
module tb_pipe_skid_reg;
  localparam int N = 32;
  localparam logic [N-1:0] INIT = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [N-1:0] out_data;
  logic [1:0] count;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [N-1:0] q[$];
  logic [N-1:0] m_main = INIT;
  bit ai, ao;

  pipe_skid_reg #(.N(N), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered list of held words, capacity two; the head is what the reader sees
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_main = INIT;
    end else begin
      if (flush) q.delete();
      else begin
        ai = in_valid && q.size() < 2;
        ao = out_ready && q.size() > 0;
        if (ao) void'(q.pop_front());
        if (ai) q.push_back(in_data);
      end
      if (q.size() > 0) m_main = q[0];
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("count", 32'(count), 32'(q.size()));
    check("out_data", out_data, m_main);
  end

  task automatic drive(logic v, logic [N-1:0] d, logic r, logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_count", 32'(count), 0);
    check("rst_data", out_data, INIT);
    check("rst_in_ready", 32'(in_ready), 1);
    drive(1, 'hA, 0, 0);
    drive(1, 'hB, 0, 0);
    check("full_count", 32'(count), 2);
    check("full_data", out_data, 'hA);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_count", 32'(count), 0);
    check("arst_data", out_data, INIT);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1, N'(i), 1, 0);
      check("stream_data", out_data, 32'(i));
      check("stream_count", 32'(count), 1);
      check("stream_in_ready", 32'(in_ready), 1);
    end
    drive(0, 0, 1, 0);
    check("stream_drain", 32'(count), 0);
    drive(1, 'h10, 0, 0);
    drive(1, 'h20, 0, 0);
    check("skid_in_ready", 32'(in_ready), 0);
    check("skid_count", 32'(count), 2);
    check("skid_data", out_data, 'h10);
    drive(1, 'h30, 0, 0);
    check("skid_ignore_count", 32'(count), 2);
    check("skid_ignore_data", out_data, 'h10);
    drive(1, 'h30, 1, 0);
    check("skid_pop_data", out_data, 'h20);
    check("skid_pop_count", 32'(count), 1);
    drive(1, 'h30, 1, 0);
    check("skid_late_data", out_data, 'h30);
    drive(0, 0, 1, 0);
    drive(1, 'h55, 0, 0);
    drive(1, 'hAA, 1, 0);
    check("simul_data", out_data, 'hAA);
    check("simul_count", 32'(count), 1);
    drive(0, 0, 1, 0);
    drive(1, 'h1, 0, 0);
    drive(1, 'h2, 0, 0);
    drive(1, 'h3, 1, 1);
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_data_kept", out_data, 'h1);
    drive(0, 0, 1, 0);
    check("flush_no_deliver", 32'(out_valid), 0);
    for (int i = 0; i < 1000; i++)
      drive(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    check("end_empty", 32'(count), 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
